// File: rtl/seven_seg_capture.sv
// Samples multiplexed 7-segment anode/cathode/dp pins and rebuilds per-digit segment and hex values.
// Optional SEVEN_SEG_CAPTURE_ERR_CNT_EN adds a saturating multi-anode error counter output.
module seven_seg_capture #(
  parameter int C_NUM_DIGITS     = 4,
  parameter int C_SETTLE_CYCLES  = 16,
  parameter int C_TIMEOUT_CYCLES = 1000000,
  parameter     C_CATHODE_POLARITY = "ACTIVE_LOW",
  parameter     C_ANODE_POLARITY   = "ACTIVE_LOW"
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [C_NUM_DIGITS-1:0]   anode_in,
  input  logic [6:0]                cathode_in,
  input  logic                      dp_in,
  output logic [C_NUM_DIGITS*8-1:0] digits,
  output logic [C_NUM_DIGITS*4-1:0] hex,
  output logic [C_NUM_DIGITS-1:0]   hex_valid,
  output logic                      frame_done,
  output logic                      stale
`ifdef SEVEN_SEG_CAPTURE_ERR_CNT_EN
  ,
  output logic [15:0]               err_cnt
`endif
);

  localparam int SW = $clog2(C_SETTLE_CYCLES + 1);
  localparam int TW = $clog2(C_TIMEOUT_CYCLES);
  localparam int IW = (C_NUM_DIGITS > 1) ? $clog2(C_NUM_DIGITS) : 1;
  localparam int WW = C_NUM_DIGITS + 8;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(C_SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(C_SETTLE_CYCLES);
  localparam logic [TW-1:0] TOUT_LAST   = TW'(C_TIMEOUT_CYCLES - 1);
  localparam bit ANODE_INV = (C_ANODE_POLARITY == "ACTIVE_LOW");
  localparam bit SEG_INV   = (C_CATHODE_POLARITY == "ACTIVE_HIGH");

  // Returns {legal, nibble} for an active-low g..a pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b1000000: decode_seg = 5'h10;
      7'b1111001: decode_seg = 5'h11;
      7'b0100100: decode_seg = 5'h12;
      7'b0110000: decode_seg = 5'h13;
      7'b0011001: decode_seg = 5'h14;
      7'b0010010: decode_seg = 5'h15;
      7'b0000010: decode_seg = 5'h16;
      7'b1111000: decode_seg = 5'h17;
      7'b0000000: decode_seg = 5'h18;
      7'b0010000: decode_seg = 5'h19;
      7'b0001000: decode_seg = 5'h1A;
      7'b0000011: decode_seg = 5'h1B;
      7'b1000110: decode_seg = 5'h1C;
      7'b0100001: decode_seg = 5'h1D;
      7'b0000110: decode_seg = 5'h1E;
      7'b0001110: decode_seg = 5'h1F;
      default:    decode_seg = 5'h00;
    endcase
  endfunction

  function automatic logic [IW-1:0] anode_index(input logic [C_NUM_DIGITS-1:0] a);
    anode_index = '0;
    for (int i = 0; i < C_NUM_DIGITS; i++)
      if (a[i]) anode_index = IW'(i);
  endfunction

  logic [C_NUM_DIGITS-1:0] anode_p0, anode_p1;
  logic [7:0]              seg_p0, seg_p1;
  logic [WW-1:0]           word_p2;
  logic [C_NUM_DIGITS-1:0] anode_n;
  logic [7:0]              seg_n;
  logic [WW-1:0]           word;
  logic [SW-1:0]           settle_cnt;
  logic [TW-1:0]           tout_cnt;
  logic [C_NUM_DIGITS-1:0] seen;
  logic [C_NUM_DIGITS-1:0] seen_next;
  logic                    settled, onehot, commit, tout;
  logic [IW-1:0]           idx;
  logic [4:0]              dec;

  // Stage p0/p1: two-flop synchroniser on raw pins
  always_ff @(posedge clk) begin
    anode_p0 <= anode_in;
    seg_p0   <= {dp_in, cathode_in};
    anode_p1 <= anode_p0;
    seg_p1   <= seg_p0;
  end

  assign anode_n = ANODE_INV ? ~anode_p1 : anode_p1;
  assign seg_n   = SEG_INV ? ~seg_p1 : seg_p1;
  assign word    = {anode_n, seg_n};

  // Stage p2: previous-cycle word for the settle comparison
  always_ff @(posedge clk) begin
    word_p2 <= word;
  end

  assign settled   = en && (word == word_p2) && (settle_cnt == SETTLE_LAST);
  assign onehot    = $onehot(anode_n);
  assign commit    = settled && onehot;
  assign tout      = en && !commit && (tout_cnt == TOUT_LAST);
  assign idx       = anode_index(anode_n);
  assign dec       = decode_seg(seg_n[6:0]);
  assign seen_next = seen | anode_n;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      settle_cnt <= '0;
      tout_cnt   <= '0;
      seen       <= '0;
    end else begin
      if (word != word_p2)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX)
        settle_cnt <= settle_cnt + SW'(1);

      if (commit)
        tout_cnt <= '0;
      else if (tout_cnt != TOUT_LAST)
        tout_cnt <= tout_cnt + TW'(1);

      if (commit)
        seen <= (&seen_next) ? '0 : seen_next;
      else if (tout)
        seen <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits     <= '1;
      hex        <= '0;
      hex_valid  <= '0;
      frame_done <= 1'b0;
      stale      <= 1'b1;
    end else begin
      frame_done <= commit && (&seen_next);
      if (commit) begin
        digits[8*idx +: 8] <= seg_n;
        hex[4*idx +: 4]    <= dec[3:0];
        hex_valid[idx]     <= dec[4];
        stale              <= 1'b0;
      end else if (tout) begin
        digits    <= '1;
        hex_valid <= '0;
        stale     <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_CAPTURE_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= '0;
    else if (settled && !onehot && (|anode_n) && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule
